// File: rtl/interp_pkg.sv
// Shared constants, types and reset-table helpers for the piecewise-linear interpolator.
package interp_pkg;
    localparam int unsigned N_KNOT         = 17;
    localparam int unsigned Y_WIDTH        = 10;
    localparam int unsigned X_WIDTH        = 8;
    localparam int unsigned FRAC_WIDTH     = 4;
    localparam int unsigned SEG_WIDTH      = 4;
    localparam int unsigned IDX_WIDTH      = 5;
    localparam int unsigned D_WIDTH        = Y_WIDTH + 1;
    localparam int unsigned P_WIDTH        = 16;
    localparam int unsigned ADDR_KNOT_BASE = 'h000;
    localparam int unsigned ADDR_CTRL      = 'h040;
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_COMMIT_BIT = 1;

    typedef logic [Y_WIDTH-1:0] knot_t;
    typedef knot_t [N_KNOT-1:0] knot_tbl_t;

    // Stage-1 payload: selected segment start, slope and position within the segment
    typedef struct packed {
        logic                  vld;
        logic                  en;
        logic [X_WIDTH-1:0]    x;
        knot_t                 y0;
        logic [D_WIDTH-1:0]    d;
        logic [FRAC_WIDTH-1:0] frac;
    } stage1_t;

    // Identity ramp y = 4*x, saturated at full scale for the last knot
    function automatic knot_t ramp_knot(input int unsigned k);
        int unsigned v;
        v = 64 * k;
        if (v > ((1 << Y_WIDTH) - 1)) begin
            v = (1 << Y_WIDTH) - 1;
        end
        return Y_WIDTH'(v);
    endfunction

    function automatic knot_tbl_t ramp_table();
        knot_tbl_t t;
        for (int unsigned k = 0; k < N_KNOT; k++) begin
            t[k] = ramp_knot(k);
        end
        return t;
    endfunction
endpackage

// File: rtl/interp_lut_regs.sv
// Register decode, shadow/active knot banks, delayed commit and single-cycle read wait.
module interp_lut_regs
    import interp_pkg::*;
#(
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [SEL_WIDTH-1:0]  i_apb_sel,
    input  logic [ADDR_WIDTH-1:0] i_apb_addr,
    input  logic [DATA_WIDTH-1:0] i_apb_data,
    input  logic                  i_apb_write_trg,
    input  logic                  i_apb_read_trg,
    output logic [DATA_WIDTH-1:0] o_apb_rdata,
    output logic                  o_apb_wait,
    output knot_tbl_t             o_active,
    output logic                  o_en
);
    knot_tbl_t             shadow_q, shadow_d;
    knot_tbl_t             active_q, active_d;
    logic                  en_q, en_d;
    logic                  commit_q, commit_d;
    logic                  wait_q, wait_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  sel_hit_c, wr_c, rd_c;
    logic                  knot_hit_c, ctrl_hit_c;
    logic [ADDR_WIDTH-1:0] off_c;
    logic [IDX_WIDTH-1:0]  idx_c;
    logic [DATA_WIDTH-1:0] rd_val_c;

    // Address decode; a write in the same cycle wins over a read
    always_comb begin
        sel_hit_c  = (i_apb_sel == SEL_WIDTH'(SEL_ID));
        wr_c       = sel_hit_c && i_apb_write_trg;
        rd_c       = sel_hit_c && i_apb_read_trg && !i_apb_write_trg && !wait_q;
        off_c      = i_apb_addr - ADDR_WIDTH'(ADDR_KNOT_BASE);
        knot_hit_c = (off_c < ADDR_WIDTH'(2 * N_KNOT));
        ctrl_hit_c = (i_apb_addr == ADDR_WIDTH'(ADDR_CTRL));
        idx_c      = off_c[IDX_WIDTH:1];
    end

    always_comb begin
        rd_val_c = '0;
        if (knot_hit_c) begin
            if (off_c[0]) begin
                rd_val_c = DATA_WIDTH'(shadow_q[idx_c][Y_WIDTH-1:8]);
            end else begin
                rd_val_c = DATA_WIDTH'(shadow_q[idx_c][7:0]);
            end
        end else if (ctrl_hit_c) begin
            rd_val_c = DATA_WIDTH'(en_q);
        end
    end

    // Commit copies the shadow as it stood before this cycle's writes land
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        en_d     = en_q;
        commit_d = 1'b0;
        wait_d   = rd_c;
        rdata_d  = rdata_q;
        if (commit_q) begin
            active_d = shadow_q;
        end
        if (wr_c && knot_hit_c) begin
            if (off_c[0]) begin
                shadow_d[idx_c][Y_WIDTH-1:8] = i_apb_data[1:0];
            end else begin
                shadow_d[idx_c][7:0] = i_apb_data[7:0];
            end
        end
        if (wr_c && ctrl_hit_c) begin
            en_d     = i_apb_data[CTRL_EN_BIT];
            commit_d = i_apb_data[CTRL_COMMIT_BIT];
        end
        if (rd_c) begin
            rdata_d = rd_val_c;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q <= ramp_table();
            active_q <= ramp_table();
            en_q     <= 1'b1;
            commit_q <= 1'b0;
            wait_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            en_q     <= en_d;
            commit_q <= commit_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_active    = active_q;
    assign o_en        = en_q;
    assign o_apb_rdata = rdata_q;
    assign o_apb_wait  = wait_q;
endmodule

// File: rtl/interp_lut_core.sv
// Programmable 17-knot piecewise-linear interpolator with a 2-stage datapath.
module interp_lut_core
    import interp_pkg::*;
#(
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [SEL_WIDTH-1:0]  i_apb_sel,
    input  logic [ADDR_WIDTH-1:0] i_apb_addr,
    input  logic [DATA_WIDTH-1:0] i_apb_data,
    input  logic                  i_apb_write_trg,
    input  logic                  i_apb_read_trg,
    output logic [DATA_WIDTH-1:0] o_apb_rdata,
    output logic                  o_apb_wait,
    input  logic                  i_x_vld,
    input  logic [X_WIDTH-1:0]    i_x,
    output logic                  o_y_vld,
    output logic [Y_WIDTH-1:0]    o_y
);
    localparam logic signed [P_WIDTH-1:0] RND_HALF = P_WIDTH'(8);

    knot_tbl_t active;
    logic      en;

    interp_lut_regs #(
        .SEL_WIDTH  (SEL_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_ID     (SEL_ID)
    ) u_regs (
        .clk             (clk),
        .rstn            (rstn),
        .i_apb_sel       (i_apb_sel),
        .i_apb_addr      (i_apb_addr),
        .i_apb_data      (i_apb_data),
        .i_apb_write_trg (i_apb_write_trg),
        .i_apb_read_trg  (i_apb_read_trg),
        .o_apb_rdata     (o_apb_rdata),
        .o_apb_wait      (o_apb_wait),
        .o_active        (active),
        .o_en            (en)
    );

    stage1_t                    s1_q, s1_d;
    logic                       y_vld_q, y_vld_d;
    logic [Y_WIDTH-1:0]         y_q, y_d;

    logic [SEG_WIDTH-1:0]       seg_c;
    knot_t                      y0_c, y1_c;
    logic signed [P_WIDTH-1:0]  d_ext_c, frac_ext_c, prod_c, rnd_c;
    logic [Y_WIDTH-1:0]         interp_c;

    // Stage 1: segment lookup and slope against the active bank
    always_comb begin
        seg_c = i_x[X_WIDTH-1:FRAC_WIDTH];
        y0_c  = active[IDX_WIDTH'(seg_c)];
        y1_c  = active[IDX_WIDTH'(seg_c) + IDX_WIDTH'(1)];
        s1_d  = s1_q;
        s1_d.vld = i_x_vld;
        if (i_x_vld) begin
            s1_d.en   = en;
            s1_d.x    = i_x;
            s1_d.y0   = y0_c;
            s1_d.d    = {1'b0, y1_c} - {1'b0, y0_c};
            s1_d.frac = i_x[FRAC_WIDTH-1:0];
        end
    end

    // Stage 2: rounded signed slope times fraction; result stays between the two knots
    always_comb begin
        d_ext_c    = {{(P_WIDTH - D_WIDTH){s1_q.d[D_WIDTH-1]}}, s1_q.d};
        frac_ext_c = {{(P_WIDTH - FRAC_WIDTH){1'b0}}, s1_q.frac};
        prod_c     = d_ext_c * frac_ext_c;
        rnd_c      = (prod_c + RND_HALF) >>> FRAC_WIDTH;
        interp_c   = Y_WIDTH'(rnd_c + $signed({{(P_WIDTH - Y_WIDTH){1'b0}}, s1_q.y0}));
        y_vld_d    = s1_q.vld;
        y_d        = y_q;
        if (s1_q.vld) begin
            y_d = s1_q.en ? interp_c : {s1_q.x, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q    <= '0;
            y_vld_q <= 1'b0;
            y_q     <= '0;
        end else begin
            s1_q    <= s1_d;
            y_vld_q <= y_vld_d;
            y_q     <= y_d;
        end
    end

    assign o_y_vld = y_vld_q;
    assign o_y     = y_q;
endmodule

// File: tb/tb_interp_lut_core.sv
// Directed plus randomized bench for interp_lut_core against a behavioural table/pipeline model.
module tb_interp_lut_core;
    logic       clk;
    logic       rstn;
    logic [3:0] i_apb_sel;
    logic [9:0] i_apb_addr;
    logic [7:0] i_apb_data;
    logic       i_apb_write_trg;
    logic       i_apb_read_trg;
    logic [7:0] o_apb_rdata;
    logic       o_apb_wait;
    logic       i_x_vld;
    logic [7:0] i_x;
    logic       o_y_vld;
    logic [9:0] o_y;

    interp_lut_core dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_apb_sel       (i_apb_sel),
        .i_apb_addr      (i_apb_addr),
        .i_apb_data      (i_apb_data),
        .i_apb_write_trg (i_apb_write_trg),
        .i_apb_read_trg  (i_apb_read_trg),
        .o_apb_rdata     (o_apb_rdata),
        .o_apb_wait      (o_apb_wait),
        .i_x_vld         (i_x_vld),
        .i_x             (i_x),
        .o_y_vld         (o_y_vld),
        .o_y             (o_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_shd[17];
    int m_act[17];
    int m_en, m_pend, m_wait, m_rdata, m_y;
    int p1v, p1y, p2v, p2y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 17; k++) begin
            m_shd[k] = (64 * k > 1023) ? 1023 : 64 * k;
            m_act[k] = m_shd[k];
        end
        m_en = 1; m_pend = 0; m_wait = 0; m_rdata = 0; m_y = 0;
        p1v = 0; p1y = 0; p2v = 0; p2y = 0;
    endtask

    function automatic int model_y(input int x);
        int seg, fr, y0, d;
        if (m_en == 0) return x * 4;
        seg = x / 16;
        fr  = x % 16;
        y0  = m_act[seg];
        d   = m_act[seg + 1] - y0;
        return y0 + ((d * fr + 8) >>> 4);
    endfunction

    function automatic int reg_val(input int a);
        if (a < 34) return (a % 2 == 1) ? (m_shd[a / 2] >> 8) & 3 : m_shd[a / 2] & 255;
        if (a == 'h40) return m_en;
        return 0;
    endfunction

    // One clock: evaluate this cycle's inputs in the model, cross the edge, compare outputs
    task automatic tick();
        int  ny, nv, a, d, rv;
        bit  hit, wr, rd;
        nv  = int'(i_x_vld);
        ny  = nv ? model_y(int'(i_x)) : 0;
        hit = (i_apb_sel == 4'd0);
        a   = int'(i_apb_addr);
        d   = int'(i_apb_data);
        wr  = hit && i_apb_write_trg;
        rd  = hit && i_apb_read_trg && !i_apb_write_trg && (m_wait == 0);
        rv  = reg_val(a);
        @(posedge clk);
        #1;
        if (m_pend != 0) begin
            for (int k = 0; k < 17; k++) m_act[k] = m_shd[k];
        end
        m_pend = 0;
        if (wr) begin
            if (a < 34) begin
                if (a % 2 == 1) m_shd[a / 2] = (m_shd[a / 2] & 255) | ((d & 3) << 8);
                else            m_shd[a / 2] = (m_shd[a / 2] & 'h300) | (d & 255);
            end else if (a == 'h40) begin
                m_en   = d & 1;
                m_pend = (d >> 1) & 1;
            end
        end
        if (rd) m_rdata = rv;
        m_wait = rd ? 1 : 0;
        p2v = p1v; p2y = p1y;
        p1v = nv;  p1y = ny;
        if (p2v != 0) m_y = p2y;
        check("y_vld", 32'(o_y_vld), 32'(p2v));
        check("y", 32'(o_y), 32'(m_y));
        check("apb_wait", 32'(o_apb_wait), 32'(m_wait));
        check("apb_rdata", 32'(o_apb_rdata), 32'(m_rdata));
    endtask

    task automatic bus_wr(input int a, input int d);
        i_apb_sel = 4'd0;
        i_apb_addr = 10'(a);
        i_apb_data = 8'(d);
        i_apb_write_trg = 1'b1;
        tick();
        i_apb_write_trg = 1'b0;
    endtask

    task automatic bus_rd(input int a, input int sel);
        i_apb_sel = 4'(sel);
        i_apb_addr = 10'(a);
        i_apb_read_trg = 1'b1;
        tick();
        i_apb_read_trg = 1'b0;
        i_apb_sel = 4'd0;
    endtask

    // Single sample; result is on o_y two cycles after it is presented
    task automatic run_sample(input int x, input int exp, input string tag);
        i_x_vld = 1'b1;
        i_x = 8'(x);
        tick();
        i_x_vld = 1'b0;
        tick();
        check(tag, 32'(o_y), 32'(exp));
    endtask

    initial begin
        rstn = 1'b0;
        i_apb_sel = '0; i_apb_addr = '0; i_apb_data = '0;
        i_apb_write_trg = 1'b0; i_apb_read_trg = 1'b0;
        i_x_vld = 1'b0; i_x = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_y_vld", 32'(o_y_vld), 0);
        check("rst_y", 32'(o_y), 0);
        check("rst_wait", 32'(o_apb_wait), 0);
        check("rst_rdata", 32'(o_apb_rdata), 0);
        rstn = 1'b1;
        tick();

        // Ramp table, back-to-back samples
        i_x_vld = 1'b1; i_x = 8'h00; tick();
        i_x = 8'h85; tick();
        check("ramp_x00", 32'(o_y), 0);
        i_x = 8'hFF; tick();
        check("ramp_x85", 32'(o_y), 532);
        i_x_vld = 1'b0; tick();
        check("ramp_xff", 32'(o_y), 1019);
        tick();

        // Shadow writes do not take effect until committed
        bus_wr('h10, 'hFF); bus_wr('h11, 'h03); bus_wr('h12, 'h00); bus_wr('h13, 'h00);
        run_sample('h88, 544, "pre_commit");
        bus_wr('h40, 'h03);
        tick();
        run_sample('h88, 512, "post_commit");

        // Register reads
        bus_rd('h11, 0);
        check("rd_wait_hi", 32'(o_apb_wait), 1);
        check("rd_knot8_hi", 32'(o_apb_rdata), 3);
        tick();
        check("rd_wait_lo", 32'(o_apb_wait), 0);
        bus_rd('h100, 0);
        check("rd_unmapped", 32'(o_apb_rdata), 0);
        tick();
        bus_rd('h11, 1);
        check("rd_badsel_wait", 32'(o_apb_wait), 0);
        check("rd_badsel_rdata", 32'(o_apb_rdata), 0);
        tick();

        // Bypass mode
        bus_wr('h40, 'h00);
        run_sample('h88, 544, "en0_bypass");
        bus_wr('h40, 'h01);
        run_sample('h88, 512, "en1_interp");

        // Commit boundary while streaming
        bus_wr('h10, 'h00); bus_wr('h11, 'h02); bus_wr('h12, 'h40); bus_wr('h13, 'h02);
        for (int c = 0; c < 10; c++) begin
            i_x_vld = 1'b1; i_x = 8'h88;
            if (c == 3) begin
                i_apb_addr = 10'h040; i_apb_data = 8'h03; i_apb_write_trg = 1'b1;
            end
            tick();
            i_apb_write_trg = 1'b0;
            if (c >= 1) check("commit_stream", 32'(o_y), (c <= 5) ? 512 : 544);
        end
        i_x_vld = 1'b0;
        tick(); tick();

        // Simultaneous write and read
        i_apb_addr = 10'h011; i_apb_data = 8'h01;
        i_apb_write_trg = 1'b1; i_apb_read_trg = 1'b1;
        tick();
        i_apb_write_trg = 1'b0; i_apb_read_trg = 1'b0;
        check("wr_rd_nowait", 32'(o_apb_wait), 0);
        bus_rd('h11, 0);
        check("wr_rd_landed", 32'(o_apb_rdata), 1);
        tick();

        // Randomized table, samples and register traffic
        for (int a = 0; a < 34; a++) bus_wr(a, int'($urandom_range(0, 255)));
        bus_wr('h40, 'h03);
        for (int c = 0; c < 300; c++) begin
            i_x_vld = ($urandom_range(0, 3) != 0);
            i_x = 8'($urandom);
            i_apb_sel = ($urandom_range(0, 5) == 0) ? 4'd1 : 4'd0;
            i_apb_addr = 10'($urandom_range(0, 'h45));
            i_apb_data = 8'($urandom);
            i_apb_write_trg = ($urandom_range(0, 5) == 0);
            i_apb_read_trg = ($urandom_range(0, 3) == 0);
            if (i_apb_write_trg && i_apb_addr == 10'h040 && $urandom_range(0, 1) == 0) i_apb_data[0] = 1'b1;
            tick();
        end
        i_apb_write_trg = 1'b0; i_apb_read_trg = 1'b0; i_apb_sel = 4'd0;
        bus_wr('h40, 'h01);

        // Reset with both pipeline stages occupied
        for (int c = 0; c < 3; c++) begin
            i_x_vld = 1'b1; i_x = 8'($urandom);
            tick();
        end
        rstn = 1'b0;
        i_x_vld = 1'b0;
        #1;
        check("midrst_y_vld", 32'(o_y_vld), 0);
        check("midrst_y", 32'(o_y), 0);
        check("midrst_wait", 32'(o_apb_wait), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        run_sample('h88, 544, "ramp_restored");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/interp_lut_core.md
Name: interp_lut_core

Overview:
Programmable piecewise-linear interpolator that maps the 8-bit sample i_x to the 10-bit result o_y.
- Holds a 17-knot Y table. Software writes it through the trigger-style register bus into a shadow bank, then commits it to the active bank.
- Computes o_y with a 2-stage pipeline.
- Sits downstream of the APB trigger generator: consumes its addr/data/sel/trigger strobes and the sample stream, and produces o_y for the output checker.

Parameters:
SEL_WIDTH, 4, width of i_apb_sel
ADDR_WIDTH, 10, register address width
DATA_WIDTH, 8, register data width (8/16/32)
SEL_ID, 0, block responds only when i_apb_sel == SEL_ID

Ports:
clk  in  1  core clock
rstn  in  1  reset
i_apb_sel  in  SEL_WIDTH  target select
i_apb_addr  in  ADDR_WIDTH  register address
i_apb_data  in  DATA_WIDTH  write data
i_apb_write_trg  in  1  single-cycle write strobe
i_apb_read_trg  in  1  single-cycle read strobe
o_apb_rdata  out  DATA_WIDTH  read data
o_apb_wait  out  1  read in progress
i_x_vld  in  1  sample valid
i_x  in  8  sample
o_y_vld  out  1  result valid
o_y  out  10  interpolated result

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rstn.
- Reset values: o_apb_rdata=0, o_apb_wait=0, o_y_vld=0, o_y=0, CTRL.EN=1.
  - Shadow and active knot k both reset to min(64*k, 1023), an identity ramp where y = 4*x.
- Address map (all other addresses: writes ignored, reads return 0):
  - 0x000+2k, k=0..16: knot k bits[7:0].
  - 0x001+2k: knot k bits[9:8] in data[1:0]. Upper data bits are ignored on write and read as 0.
  - 0x040 CTRL: bit0 EN (RW); bit1 COMMIT (write-1 pulse, reads 0).
- Register access applies only when i_apb_sel==SEL_ID.
  - Write: the target register updates at the edge ending the trigger cycle. o_apb_wait is never raised for writes.
  - Read: o_apb_wait=1 in the cycle after the trigger. o_apb_rdata is valid in that same cycle and holds until the next read.
  - A read trigger arriving while o_apb_wait=1 is ignored.
  - write_trg and read_trg in the same cycle: the write is performed, the read is ignored.
- Commit timing: a COMMIT write in cycle T loads active := shadow at the edge ending T+1.
  - Samples accepted in cycles ≤T+1 use the old table; samples from T+2 onward use the new one.
  - Shadow writes in cycle T+1 are not included in that commit.
- Datapath:
  - seg = i_x[7:4], frac = i_x[3:0].
  - Stage 1 registers y0 = active[seg], d = active[seg+1] - y0 (11-bit signed), frac, vld.
  - Stage 2: o_y = y0 + ((d*frac + 8) >>> 4). The product is 15-bit signed and the shift is arithmetic.
  - The result always lies between y0 and y1, so no clamp is needed.
- Latency: i_x_vld in cycle T gives o_y_vld in cycle T+2. Throughput is 1 sample per cycle.
  - o_y holds its last value when o_y_vld=0.
- EN=0: o_y = {i_x, 2'b00} with the same 2-cycle latency. EN is sampled at stage 1.
- Reset mid-operation: all pipeline valids clear immediately; both tables return to the ramp; any pending commit or read is dropped.

Decomposition:
- Package interp_pkg holds:
  - N_KNOT=17 and Y_WIDTH=10
  - address constants ADDR_KNOT_BASE=0x000 and ADDR_CTRL=0x040
  - CTRL bit indices
  - typedef knot_t (logic [9:0]) and the reset-ramp function.
- Sub-module interp_lut_regs contains the register decode, shadow/active banks, commit and read-wait logic. It exports the active table and EN to the 2-stage datapath in interp_lut_core.

Test Plan:
- Reset table, samples x=0x00, 0x85, 0xFF back-to-back → o_y = 0, 532, 1019 on three consecutive cycles starting 2 cycles after the first sample.
- Write knot 8 = 0x3FF (0x010←0xFF, 0x011←0x03) and knot 9 = 0 (0x012←0, 0x013←0):
  - without COMMIT, x=0x88 → 544;
  - after COMMIT, x=0x88 → 512.
- Read 0x011 after the previous write → o_apb_wait=1 for exactly 1 cycle with o_apb_rdata=0x03.
  - Read 0x100 → 0.
  - Read with sel≠SEL_ID → no wait and rdata unchanged.
- Custom table loaded, CTRL←0 (EN=0), x=0x88 → 544.
  - CTRL←1, x=0x88 → 512.
- Streaming x every cycle with COMMIT in cycle T → samples up to T+1 use the old table and from T+2 the new one.
  - Same-cycle write+read to 0x011 → write lands, no wait.
- Pulse rstn low while both pipeline stages are valid → o_y_vld=0 immediately; after release, x=0x88 → 544 (ramp restored).
